// File: rtl/step_detector.sv
// Step detector: hysteresis threshold FSM on the dynamic acceleration magnitude.
// A candidate step opens at THRESH_HI, stays open down to THRESH_LO, and is
// accepted only when it lasted at least MIN_HIGH samples and fewer than
// MAX_HIGH samples. After a step or an abort, REFRACT valid samples are ignored.
module step_detector #(
    parameter logic [15:0] THRESH_HI = 16'd800,
    parameter logic [15:0] THRESH_LO = 16'd400,
    parameter int unsigned MIN_HIGH  = 2,
    parameter int unsigned MAX_HIGH  = 64,
    parameter int unsigned REFRACT   = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] z_dynamic_abs,
    input  logic        dyn_valid,
    input  logic        clear_count,
    output logic        step_pulse,
    output logic [15:0] step_count,
    output logic [15:0] peak_mag,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HIGH    = 2'd1,
        ST_REFRACT = 2'd2
    } state_t;

    localparam logic [7:0] MIN_HIGH_C = 8'(MIN_HIGH);
    localparam logic [7:0] MAX_HIGH_C = 8'(MAX_HIGH);
    localparam logic [7:0] REFRACT_C  = 8'(REFRACT);

    state_t      state;
    logic [7:0]  high_cnt;
    logic [7:0]  ref_cnt;
    logic [15:0] peak_run;

    logic        above_hi;
    logic        above_lo;
    logic [7:0]  high_cnt_inc;
    logic        step_event;

    // Threshold decodes and the accept condition, shared by the FSM and the counter
    always_comb begin
        above_hi     = (z_dynamic_abs >= THRESH_HI);
        above_lo     = (z_dynamic_abs >= THRESH_LO);
        high_cnt_inc = high_cnt + 8'd1;
        step_event   = dyn_valid && (state == ST_HIGH) && !above_lo
                       && (high_cnt >= MIN_HIGH_C);
    end

    // Detection FSM; only valid samples advance it, everything holds otherwise
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            high_cnt   <= 8'd0;
            ref_cnt    <= 8'd0;
            peak_run   <= 16'd0;
            step_pulse <= 1'b0;
            peak_mag   <= 16'd0;
        end else begin
            step_pulse <= 1'b0;
            if (dyn_valid) begin
                case (state)
                    ST_IDLE: begin
                        if (above_hi) begin
                            state    <= ST_HIGH;
                            high_cnt <= 8'd1;
                            peak_run <= z_dynamic_abs;
                        end
                    end
                    ST_HIGH: begin
                        if (above_lo) begin
                            high_cnt <= high_cnt_inc;
                            if (z_dynamic_abs > peak_run) begin
                                peak_run <= z_dynamic_abs;
                            end
                            if (high_cnt_inc == MAX_HIGH_C) begin
                                state   <= ST_REFRACT;
                                ref_cnt <= REFRACT_C;
                            end
                        end else if (high_cnt >= MIN_HIGH_C) begin
                            step_pulse <= 1'b1;
                            peak_mag   <= peak_run;
                            state      <= ST_REFRACT;
                            ref_cnt    <= REFRACT_C;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                    ST_REFRACT: begin
                        ref_cnt <= ref_cnt - 8'd1;
                        if (ref_cnt == 8'd1) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Saturating step total; a clear wins over a coincident step
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step_count <= 16'd0;
        end else if (clear_count) begin
            step_count <= 16'd0;
        end else if (step_event && (step_count != 16'hFFFF)) begin
            step_count <= step_count + 16'd1;
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_step_detector.sv
// Self-checking bench for step_detector: a behavioural model pushes the
// expected outputs for every driven cycle into a queue, and each scenario pops
// and compares them one clock after the stimulus, plus fixed spot checks.
module tb_step_detector;

    localparam logic [15:0] THRESH_HI = 16'd800;
    localparam logic [15:0] THRESH_LO = 16'd400;
    localparam int MIN_HIGH = 2;
    localparam int MAX_HIGH = 64;
    localparam int REFRACT  = 20;

    logic        clk;
    logic        reset;
    logic [15:0] z_dynamic_abs;
    logic        dyn_valid;
    logic        clear_count;
    logic        step_pulse;
    logic [15:0] step_count;
    logic [15:0] peak_mag;
    logic [1:0]  state_dbg;

    int checks;
    int failures;

    // expected {pulse, count, peak, state}
    logic [34:0] sb[$];
    logic [34:0] exp_v;
    logic [34:0] got_v;

    int          m_state;
    int          m_high;
    int          m_ref;
    logic [15:0] m_peak_run;
    logic [15:0] m_count;
    logic [15:0] m_peak;
    logic        m_pulse;

    step_detector #(
        .THRESH_HI(THRESH_HI),
        .THRESH_LO(THRESH_LO),
        .MIN_HIGH(MIN_HIGH),
        .MAX_HIGH(MAX_HIGH),
        .REFRACT(REFRACT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .z_dynamic_abs(z_dynamic_abs),
        .dyn_valid(dyn_valid),
        .clear_count(clear_count),
        .step_pulse(step_pulse),
        .step_count(step_count),
        .peak_mag(peak_mag),
        .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign got_v = {step_pulse, step_count, peak_mag, state_dbg};

    task automatic model_reset();
        m_state = 0; m_high = 0; m_ref = 0;
        m_peak_run = 16'd0; m_count = 16'd0; m_peak = 16'd0; m_pulse = 1'b0;
        sb.delete();
    endtask

    task automatic model_update(input logic v, input logic [15:0] s, input logic clr);
        m_pulse = 1'b0;
        if (v) begin
            case (m_state)
                0: if (s >= THRESH_HI) begin
                    m_state = 1; m_high = 1; m_peak_run = s;
                end
                1: if (s >= THRESH_LO) begin
                    m_high = m_high + 1;
                    if (s > m_peak_run) m_peak_run = s;
                    if (m_high == MAX_HIGH) begin
                        m_state = 2; m_ref = REFRACT;
                    end
                end else if (m_high >= MIN_HIGH) begin
                    m_pulse = 1'b1;
                    if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
                    m_peak = m_peak_run;
                    m_state = 2; m_ref = REFRACT;
                end else begin
                    m_state = 0;
                end
                default: begin
                    m_ref = m_ref - 1;
                    if (m_ref == 0) m_state = 0;
                end
            endcase
        end
        if (clr) m_count = 16'd0;
        sb.push_back({m_pulse, m_count, m_peak, 2'(m_state)});
    endtask

    // one clock of stimulus; returns #1 after the sampling edge
    task automatic drive(input logic v, input logic [15:0] s, input logic clr);
        @(negedge clk);
        dyn_valid = v;
        z_dynamic_abs = s;
        clear_count = clr;
        model_update(v, s, clr);
        @(posedge clk);
        #1;
        dyn_valid = 1'b0;
        clear_count = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        dyn_valid = 1'b0;
        clear_count = 1'b0;
        model_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (step_pulse !== 1'b0) begin failures++; $display("FAIL reset_pulse got=%0b want=0", step_pulse); end
        checks++;
        if (step_count !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d want=0", step_count); end
        checks++;
        if (peak_mag !== 16'd0) begin failures++; $display("FAIL reset_peak got=%0d want=0", peak_mag); end
        checks++;
        if (state_dbg !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d want=0", state_dbg); end
    endtask

    task automatic test_basic_step();
        int seq [5] = '{100, 900, 950, 500, 300};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 16'(seq[i]), 1'b0);
            exp_v = sb.pop_front();
            checks++;
            if (got_v !== exp_v) begin failures++; $display("FAIL basic[%0d] got=%h want=%h", i, got_v, exp_v); end
        end
        checks++;
        if (got_v !== {1'b1, 16'd1, 16'd950, 2'd2}) begin
            failures++; $display("FAIL basic_result got=%h want=%h", got_v, {1'b1, 16'd1, 16'd950, 2'd2});
        end
        drive(1'b0, 16'd0, 1'b0);
        exp_v = sb.pop_front();
        checks++;
        if (got_v !== exp_v) begin failures++; $display("FAIL basic_pulse_end got=%h want=%h", got_v, exp_v); end
    endtask

    task automatic test_glitch();
        int seq [2] = '{900, 300};
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 16'(seq[i]), 1'b0);
            exp_v = sb.pop_front();
            checks++;
            if (got_v !== exp_v) begin failures++; $display("FAIL glitch[%0d] got=%h want=%h", i, got_v, exp_v); end
        end
        checks++;
        if (got_v !== {1'b0, 16'd0, 16'd0, 2'd0}) begin
            failures++; $display("FAIL glitch_result got=%h want=%h", got_v, {1'b0, 16'd0, 16'd0, 2'd0});
        end
    endtask

    task automatic test_threshold_edges();
        int seq [4] = '{799, 800, 400, 399};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'(seq[i]), 1'b0);
            exp_v = sb.pop_front();
            checks++;
            if (got_v !== exp_v) begin failures++; $display("FAIL edges[%0d] got=%h want=%h", i, got_v, exp_v); end
        end
        checks++;
        if (got_v !== {1'b1, 16'd1, 16'd800, 2'd2}) begin
            failures++; $display("FAIL edges_result got=%h want=%h", got_v, {1'b1, 16'd1, 16'd800, 2'd2});
        end
    endtask

    task automatic test_refractory();
        int seq [3] = '{900, 900, 100};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'(seq[i]), 1'b0);
            exp_v = sb.pop_front();
            checks++;
            if (got_v !== exp_v) begin failures++; $display("FAIL refr_first[%0d] got=%h want=%h", i, got_v, exp_v); end
        end
        for (int i = 0; i < REFRACT; i++) begin
            drive(1'b1, 16'd1000, 1'b0);
            exp_v = sb.pop_front();
            checks++;
            if (got_v !== exp_v) begin failures++; $display("FAIL refr_hold[%0d] got=%h want=%h", i, got_v, exp_v); end
            if (i == REFRACT - 2) begin
                checks++;
                if (state_dbg !== 2'd2) begin failures++; $display("FAIL refr_19th got=%0d want=2", state_dbg); end
            end
        end
        checks++;
        if (state_dbg !== 2'd0) begin failures++; $display("FAIL refr_20th got=%0d want=0", state_dbg); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'(seq[i]), 1'b0);
            exp_v = sb.pop_front();
            checks++;
            if (got_v !== exp_v) begin failures++; $display("FAIL refr_second[%0d] got=%h want=%h", i, got_v, exp_v); end
        end
        checks++;
        if (step_count !== 16'd2) begin failures++; $display("FAIL refr_count got=%0d want=2", step_count); end
    endtask

    task automatic test_abort();
        do_reset();
        for (int i = 0; i < MAX_HIGH; i++) begin
            drive(1'b1, 16'd900, 1'b0);
            exp_v = sb.pop_front();
            checks++;
            if (got_v !== exp_v) begin failures++; $display("FAIL abort[%0d] got=%h want=%h", i, got_v, exp_v); end
            if (i == MAX_HIGH - 2) begin
                checks++;
                if (state_dbg !== 2'd1) begin failures++; $display("FAIL abort_63rd got=%0d want=1", state_dbg); end
            end
        end
        checks++;
        if (got_v !== {1'b0, 16'd0, 16'd0, 2'd2}) begin
            failures++; $display("FAIL abort_result got=%h want=%h", got_v, {1'b0, 16'd0, 16'd0, 2'd2});
        end
    endtask

    task automatic test_clear_same_cycle();
        do_reset();
        // first step to get a non-zero count, clear asserted mid-candidate
        drive(1'b1, 16'd900, 1'b0);
        drive(1'b1, 16'd900, 1'b1);
        drive(1'b1, 16'd100, 1'b0);
        for (int i = 0; i < REFRACT; i++) drive(1'b1, 16'd0, 1'b0);
        drive(1'b1, 16'd950, 1'b0);
        drive(1'b1, 16'd900, 1'b0);
        drive(1'b1, 16'd100, 1'b1);
        while (sb.size() > 0) begin
            exp_v = sb.pop_front();
            if (sb.size() == 0) begin
                checks++;
                if (got_v !== exp_v) begin failures++; $display("FAIL clear_step got=%h want=%h", got_v, exp_v); end
            end
        end
        checks++;
        if (got_v !== {1'b1, 16'd0, 16'd950, 2'd2}) begin
            failures++; $display("FAIL clear_result got=%h want=%h", got_v, {1'b1, 16'd0, 16'd950, 2'd2});
        end
    endtask

    task automatic test_saturation();
        do_reset();
        @(negedge clk);
        force dut.step_count = 16'hFFFE;
        #1;
        release dut.step_count;
        m_count = 16'hFFFE;
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 16'd900, 1'b0);
            drive(1'b1, 16'd900, 1'b0);
            drive(1'b1, 16'd100, 1'b0);
            void'(sb.pop_front());
            void'(sb.pop_front());
            exp_v = sb.pop_front();
            checks++;
            if (got_v !== exp_v) begin failures++; $display("FAIL sat_step[%0d] got=%h want=%h", k, got_v, exp_v); end
            checks++;
            if ({step_pulse, step_count} !== {1'b1, 16'hFFFF}) begin
                failures++; $display("FAIL sat_value[%0d] got=%h want=1ffff", k, {step_pulse, step_count});
            end
            for (int i = 0; i < REFRACT; i++) begin
                drive(1'b1, 16'd0, 1'b0);
                exp_v = sb.pop_front();
                checks++;
                if (got_v !== exp_v) begin failures++; $display("FAIL sat_refr[%0d] got=%h want=%h", i, got_v, exp_v); end
            end
        end
    endtask

    task automatic test_reset_mid_high();
        int seq [3] = '{900, 900, 100};
        do_reset();
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 3; i++) begin
                drive(1'b1, 16'(seq[i]), 1'b0);
                exp_v = sb.pop_front();
                checks++;
                if (got_v !== exp_v) begin failures++; $display("FAIL rst_pre[%0d] got=%h want=%h", i, got_v, exp_v); end
            end
            for (int i = 0; i < REFRACT; i++) drive(1'b1, 16'd0, 1'b0);
            // enter HIGH (pass 0) or stop inside REFRACT after a step (pass 1)
            drive(1'b1, 16'd1200, 1'b0);
            if (pass == 1) begin
                drive(1'b1, 16'd1200, 1'b0);
                drive(1'b1, 16'd10, 1'b0);
                drive(1'b1, 16'd10, 1'b0);
            end
            sb.delete();
            #2;
            reset = 1'b0;
            #1;
            checks++;
            if (got_v !== 35'd0) begin failures++; $display("FAIL rst_async[%0d] got=%h want=0", pass, got_v); end
            model_reset();
            @(negedge clk);
            #2;
            reset = 1'b1;
        end
        for (int i = 0; i < 3; i++) begin
            for (int g = $urandom_range(0, 5); g > 0; g--) begin
                drive(1'b0, 16'(seq[i]), 1'b0);
                exp_v = sb.pop_front();
                checks++;
                if (got_v !== exp_v) begin failures++; $display("FAIL rst_gap[%0d] got=%h want=%h", i, got_v, exp_v); end
            end
            drive(1'b1, 16'(seq[i]), 1'b0);
            exp_v = sb.pop_front();
            checks++;
            if (got_v !== exp_v) begin failures++; $display("FAIL rst_post[%0d] got=%h want=%h", i, got_v, exp_v); end
        end
        checks++;
        if ({step_count, peak_mag} !== {16'd1, 16'd900}) begin
            failures++; $display("FAIL rst_result got=%h want=%h", {step_count, peak_mag}, {16'd1, 16'd900});
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b0;
        dyn_valid = 1'b0;
        clear_count = 1'b0;
        z_dynamic_abs = 16'd0;
        model_reset();
        test_reset();
        test_basic_step();
        test_glitch();
        test_threshold_edges();
        test_refractory();
        test_abort();
        test_clear_same_cycle();
        test_saturation();
        test_reset_mid_high();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/step_detector.md
STEP_DETECTOR -- requirements
Module: step_detector

Interface
REQ-001 SHALL have parameter THRESH_HI, 16'd800: rising threshold on dynamic magnitude; a candidate step starts when a sample is >= this value.
REQ-002 SHALL have parameter THRESH_LO, 16'd400: falling threshold, hysteresis; the candidate ends when a sample is < this value; THRESH_LO < THRESH_HI is required.
REQ-003 SHALL have parameter MIN_HIGH, 2: minimum number of qualifying samples (the entry sample counts) for a candidate to be a valid step; range 1..255.
REQ-004 SHALL have parameter MAX_HIGH, 64: candidate length in samples that triggers an abort as sustained vibration; range MIN_HIGH..255.
REQ-005 SHALL have parameter REFRACT, 20: number of valid samples ignored after a step or abort; range 1..255.
REQ-006 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-007 SHALL have port reset, input, 1: asynchronous, active-low reset; 0 = reset.
REQ-008 SHALL have port z_dynamic_abs, input, 16: unsigned dynamic acceleration magnitude from the preprocess stage.
REQ-009 SHALL have port dyn_valid, input, 1: one-cycle strobe marking z_dynamic_abs valid; any duty cycle, including back-to-back.
REQ-010 SHALL have port clear_count, input, 1: synchronous request to zero step_count.
REQ-011 SHALL have port step_pulse, output, 1: one-cycle strobe per detected step.
REQ-012 SHALL have port step_count, output, 16: running step total.
REQ-013 SHALL have port peak_mag, output, 16: peak magnitude of the most recent accepted step.
REQ-014 SHALL have port state_dbg, output, 2: current FSM state encoding (IDLE=0, HIGH=1, REFRACT=2).

Function
REQ-015 SHALL evaluate the FSM only in cycles with dyn_valid=1; state, counters and peak SHALL hold in all other cycles.
REQ-016 SHALL, in IDLE, on a sample >= THRESH_HI, go to HIGH with high_cnt=1 and peak_run=sample; otherwise SHALL stay in IDLE.
REQ-017 SHALL, in HIGH, on a sample >= THRESH_LO, increment high_cnt and set peak_run=max(peak_run, sample).
REQ-018 SHALL, in HIGH, when the increment makes high_cnt reach MAX_HIGH, go to REFRACT with no step_pulse and no count change (abort).
REQ-019 SHALL, in HIGH, on a sample < THRESH_LO with high_cnt >= MIN_HIGH, assert step_pulse, increment step_count, load peak_mag=peak_run, and go to REFRACT.
REQ-020 SHALL, in HIGH, on a sample < THRESH_LO with high_cnt < MIN_HIGH, return to IDLE with no pulse (glitch rejection).
REQ-021 SHALL, on entry to REFRACT, load ref_cnt=REFRACT; each valid sample in REFRACT SHALL decrement ref_cnt, and the decrement to 0 SHALL move the FSM to IDLE regardless of sample value.
REQ-022 SHALL register outputs: step_pulse, step_count, peak_mag and state_dbg update on the clock edge that samples the deciding dyn_valid, giving 1-cycle latency; step_pulse is high for exactly one cycle.
REQ-023 SHALL saturate step_count at 16'hFFFF; step_pulse SHALL still assert at saturation.
REQ-024 SHALL, on clear_count=1, set step_count to 0 on the next edge; a simultaneous step SHALL give step_count=0 with step_pulse still asserted, and clear_count SHALL NOT affect FSM state or peak_mag.
REQ-025 SHALL compare thresholds unsigned and inclusive as stated; a sample exactly equal to THRESH_LO counts as high.

Reset
REQ-026 SHALL, while reset=0, immediately force state=IDLE, high_cnt=0, ref_cnt=0, peak_run=0, step_pulse=0, step_count=0, peak_mag=0, state_dbg=0, including in the middle of HIGH or REFRACT.
REQ-027 SHALL ignore dyn_valid on the first rising edge after reset deasserts only if it is coincident with deassertion; processing is normal from the next edge.

Verification
REQ-028 Valid samples 100, 900, 950, 500, 300 -> step_pulse one cycle after the 300 sample, step_count=1, peak_mag=950, state_dbg=2.
REQ-029 Samples 900, 300 with MIN_HIGH=2 -> no pulse, step_count=0, back to IDLE after the 300 sample.
REQ-030 Step accepted, then 19 samples of 1000 -> no new step; the 20th valid sample returns to IDLE; a subsequent 900, 900, 100 -> step_count=2.
REQ-031 Sixty-four consecutive samples of 900 -> abort to REFRACT at the 64th, no pulse, step_count unchanged.
REQ-032 clear_count asserted in the same cycle as a step -> step_pulse=1, step_count=0; preload 16'hFFFF via 65535 steps (or force) plus one more step -> stays 16'hFFFF with the pulse.
REQ-033 reset=0 asserted mid-HIGH with dyn_valid gaps of 0-5 idle cycles -> all outputs 0 asynchronously; after release, 900, 900, 100 -> step_count=1, peak_mag=900.
